// File: rtl/aes_decipher_block_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the
// AES inverse cipher datapath.
package aes_decipher_block_pkg;

    localparam logic       KEYLEN_128 = 1'b0;
    localparam logic       KEYLEN_256 = 1'b1;
    localparam logic [3:0] NR_128     = 4'd10;
    localparam logic [3:0] NR_256     = 4'd14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SHIFT,
        ST_SBOX,
        ST_MAIN
    } state_t;

    function automatic logic [3:0] nr_of(input logic kl);
        return (kl == KEYLEN_256) ? NR_256 : NR_128;
    endfunction

    // xtime: multiply by x modulo 0x11b
    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm4(input logic [7:0] b);
        return gm2(gm2(b));
    endfunction

    function automatic logic [7:0] gm8(input logic [7:0] b);
        return gm2(gm4(b));
    endfunction

    function automatic logic [7:0] gm09(input logic [7:0] b);
        return gm8(b) ^ b;
    endfunction

    function automatic logic [7:0] gm0b(input logic [7:0] b);
        return gm8(b) ^ gm2(b) ^ b;
    endfunction

    function automatic logic [7:0] gm0d(input logic [7:0] b);
        return gm8(b) ^ gm4(b) ^ b;
    endfunction

    function automatic logic [7:0] gm0e(input logic [7:0] b);
        return gm8(b) ^ gm4(b) ^ gm2(b);
    endfunction

    function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {gm0e(a0) ^ gm0b(a1) ^ gm0d(a2) ^ gm09(a3),
                gm09(a0) ^ gm0e(a1) ^ gm0b(a2) ^ gm0d(a3),
                gm0d(a0) ^ gm09(a1) ^ gm0e(a2) ^ gm0b(a3),
                gm0b(a0) ^ gm0d(a1) ^ gm09(a2) ^ gm0e(a3)};
    endfunction

endpackage

// File: rtl/aes_decipher_block_if.sv
// Control/data bundle between the key-memory side and the
// inverse cipher block.
interface aes_decipher_block_if;

    logic         next;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;

    modport master (
        output next,
        output keylen,
        output round_key,
        output block,
        input  round,
        input  new_block,
        input  ready
    );

    modport slave (
        input  next,
        input  keylen,
        input  round_key,
        input  block,
        output round,
        output new_block,
        output ready
    );

endinterface

// File: rtl/aes_decipher_block_inv_sbox.sv
// Combinational inverse S-box over one 32-bit word
// (four independent byte lookups).
module aes_inv_sbox (
    input  logic [31:0] sword,
    output logic [31:0] new_sword
);

    // Row-major table, entry k at bits [(255-k)*8 +: 8]
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_byte(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return INV_SBOX[idx +: 8];
    endfunction

    assign new_sword[31:24] = inv_byte(sword[31:24]);
    assign new_sword[23:16] = inv_byte(sword[23:16]);
    assign new_sword[15:8]  = inv_byte(sword[15:8]);
    assign new_sword[7:0]   = inv_byte(sword[7:0]);

endmodule

// File: rtl/aes_decipher_block.sv
// Iterative AES-128/256 inverse cipher: one round per six cycles,
// a single shared 32-bit inverse S-box, round keys fetched by index.
module aes_decipher_block
    import aes_decipher_block_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    aes_decipher_block_if.slave   bus
);

    state_t       state;
    logic [3:0]   round_ctr;
    logic [1:0]   word_ctr;
    logic         keylen_reg;
    logic [127:0] blk;
    logic         ready_reg;
    logic [31:0]  sb_in;
    logic [31:0]  sb_out;

    function automatic logic [127:0] inv_shift_rows(
        input logic [127:0] s
    );
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (r + 4 * c) -: 8] =
                    s[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(
        input logic [127:0] s
    );
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32 * c -: 32] = inv_mix_word(s[127 - 32 * c -: 32]);
        end
        return o;
    endfunction

    always_comb begin
        sb_in = blk[127:96];
        unique case (word_ctr)
            2'd0: sb_in = blk[127:96];
            2'd1: sb_in = blk[95:64];
            2'd2: sb_in = blk[63:32];
            2'd3: sb_in = blk[31:0];
        endcase
    end

    aes_inv_sbox u_inv_sbox (
        .sword     (sb_in),
        .new_sword (sb_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            ready_reg  <= 1'b1;
            blk        <= '0;
            round_ctr  <= 4'd0;
            word_ctr   <= 2'd0;
            keylen_reg <= KEYLEN_128;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.next) begin
                        keylen_reg <= bus.keylen;
                        round_ctr  <= nr_of(bus.keylen);
                        ready_reg  <= 1'b0;
                        state      <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    blk       <= bus.block ^ bus.round_key;
                    // recomputed from the latched length, equals round_ctr-1
                    round_ctr <= nr_of(keylen_reg) - 4'd1;
                    state     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    blk      <= inv_shift_rows(blk);
                    word_ctr <= 2'd0;
                    state    <= ST_SBOX;
                end
                ST_SBOX: begin
                    unique case (word_ctr)
                        2'd0: blk[127:96] <= sb_out;
                        2'd1: blk[95:64]  <= sb_out;
                        2'd2: blk[63:32]  <= sb_out;
                        2'd3: blk[31:0]   <= sb_out;
                    endcase
                    word_ctr <= word_ctr + 2'd1;
                    if (word_ctr == 2'd3) begin
                        state <= ST_MAIN;
                    end
                end
                ST_MAIN: begin
                    if (round_ctr != 4'd0) begin
                        blk       <= inv_mix_columns(blk ^ bus.round_key);
                        round_ctr <= round_ctr - 4'd1;
                        state     <= ST_SHIFT;
                    end else begin
                        blk       <= blk ^ bus.round_key;
                        ready_reg <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.round     = round_ctr;
    assign bus.new_block = blk;
    assign bus.ready     = ready_reg;

endmodule

// File: tb/tb_aes_decipher_block.sv
// Bench for aes_decipher_block: FIPS-197 vectors and random blocks
// against a byte-level inverse cipher with its own key expansion.
module tb_aes_decipher_block;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    aes_decipher_block_if bus ();

    aes_decipher_block dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [127:0] rkeys [0:15];
    assign bus.round_key = rkeys[bus.round];

    logic [7:0] sbox_f [256];
    logic [7:0] sbox_i [256];
    int rq[$];
    int total = 0;
    int bad = 0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        if (a == 0) return 8'h00;
        for (int x = 1; x < 256; x++)
            if (gmul(a, 8'(x)) == 8'h01) return 8'(x);
        return 8'h00;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_f[w[31:24]], sbox_f[w[23:16]], sbox_f[w[15:8]], sbox_f[w[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input logic kl);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0] rc;
        int nk, nr;
        nk = kl ? 8 : 4;
        nr = kl ? 14 : 10;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int r = 0; r < 16; r++) rkeys[r] = '0;
        for (int r = 0; r <= nr; r++)
            rkeys[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    function automatic logic [127:0] model(input logic [127:0] ct, input int nr);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++)
            s[i] = ct[127 - 8 * i -: 8] ^ rkeys[nr][127 - 8 * i -: 8];
        for (int r = nr - 1; r >= 0; r--) begin
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    t[w + 4 * c] = s[w + 4 * ((c - w + 4) % 4)];
            for (int i = 0; i < 16; i++)
                s[i] = sbox_i[t[i]] ^ rkeys[r][127 - 8 * i -: 8];
            if (r > 0) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4 * c]; a1 = s[4 * c + 1];
                    a2 = s[4 * c + 2]; a3 = s[4 * c + 3];
                    s[4*c]   = gmul(a0, 14) ^ gmul(a1, 11) ^ gmul(a2, 13) ^ gmul(a3, 9);
                    s[4*c+1] = gmul(a0, 9) ^ gmul(a1, 14) ^ gmul(a2, 11) ^ gmul(a3, 13);
                    s[4*c+2] = gmul(a0, 13) ^ gmul(a1, 9) ^ gmul(a2, 14) ^ gmul(a3, 11);
                    s[4*c+3] = gmul(a0, 11) ^ gmul(a1, 13) ^ gmul(a2, 9) ^ gmul(a3, 14);
                end
            end
        end
        for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = s[i];
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic bit seq_ok(input int nr);
        if (rq.size() != nr + 1) return 1'b0;
        for (int i = 0; i <= nr; i++)
            if (rq[i] != nr - i) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run(input logic kl, input logic [127:0] ct, input bit disturb,
                       output int lat, output logic [127:0] nb0);
        bus.keylen = kl;
        bus.block = ct;
        bus.next = 1'b1;
        @(posedge clk); #1;
        nb0 = bus.new_block;
        bus.next = 1'b0;
        lat = 0;
        rq.delete();
        rq.push_back(int'(bus.round));
        while (bus.ready !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (int'(bus.round) != rq[$]) rq.push_back(int'(bus.round));
            if (disturb) begin
                bus.next = 1'b1;
                bus.keylen = ~bus.keylen;
                bus.block = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
        end
        bus.next = 1'b0;
        bus.keylen = kl;
    endtask

    localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] K3  =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PC  = 128'h00112233445566778899aabbccddeeff;

    initial begin
        int lat;
        logic [127:0] nb0, hold;
        logic [255:0] rk;
        logic kl;
        logic [127:0] ct;

        for (int a = 0; a < 256; a++) begin
            logic [7:0] b, s;
            b = ginv(8'(a));
            s = b ^ rol8(b, 1) ^ rol8(b, 2) ^ rol8(b, 3) ^ rol8(b, 4) ^ 8'h63;
            sbox_f[a] = s;
            sbox_i[s] = 8'(a);
        end
        for (int r = 0; r < 16; r++) rkeys[r] = '0;

        bus.next = 1'b0;
        bus.keylen = 1'b0;
        bus.block = '0;
        #1 reset = 1'b1;
        #1;
        chk("rst_ready", bus.ready, 1);
        chk("rst_block", bus.new_block, 0);
        chk("rst_round", bus.round, 0);
        @(negedge clk) reset = 1'b0;

        // App. B, AES-128
        expand({KB, 128'h0}, 1'b0);
        run(1'b0, CB, 1'b0, lat, nb0);
        chk("appB_pt", bus.new_block, PB);
        chk("appB_lat", lat, 61);
        chk("appB_rseq", seq_ok(10), 1);

        hold = bus.new_block;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_hold", bus.new_block, hold);

        // C.1 with next held high and keylen toggling mid-run
        expand({K1, 128'h0}, 1'b0);
        run(1'b0, C1, 1'b1, lat, nb0);
        chk("c1_dist_pt", bus.new_block, PC);
        chk("c1_dist_lat", lat, 61);
        chk("c1_dist_rseq", seq_ok(10), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("c1_next_ign", bus.ready, 1);
        chk("c1_next_hold", bus.new_block, PC);

        // C.3, AES-256
        expand(K3, 1'b1);
        run(1'b1, C3, 1'b0, lat, nb0);
        chk("c3_pt", bus.new_block, PC);
        chk("c3_lat", lat, 85);
        chk("c3_rseq", seq_ok(14), 1);

        // back-to-back: next on the cycle after ready rises
        expand({KB, 128'h0}, 1'b0);
        run(1'b0, CB, 1'b0, lat, nb0);
        chk("b2b_hold", nb0, PC);
        chk("b2b_pt", bus.new_block, PB);
        chk("b2b_lat", lat, 61);

        // reset in the middle of a decryption
        expand({K1, 128'h0}, 1'b0);
        bus.keylen = 1'b0;
        bus.block = C1;
        bus.next = 1'b1;
        @(posedge clk); #1;
        bus.next = 1'b0;
        repeat (30) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_ready", bus.ready, 1);
        chk("abort_block", bus.new_block, 0);
        chk("abort_round", bus.round, 0);
        @(negedge clk) reset = 1'b0;
        run(1'b0, C1, 1'b0, lat, nb0);
        chk("post_rst_pt", bus.new_block, PC);
        chk("post_rst_lat", lat, 61);

        // random keys, lengths and ciphertexts
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < 8; k++) rk[32 * k +: 32] = $urandom();
            kl = 1'($urandom_range(0, 1));
            ct = {$urandom(), $urandom(), $urandom(), $urandom()};
            expand(rk, kl);
            run(kl, ct, 1'b0, lat, nb0);
            chk("rand_pt", bus.new_block, model(ct, kl ? 14 : 10));
            chk("rand_lat", lat, kl ? 85 : 61);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_decipher_block.md
AES_DECIPHER_BLOCK -- requirements
Module: aes_decipher_block

Interface
REQ-001 Parameters: none; key length is selected at run time through keylen.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- next  in  1  start pulse for one block decryption.
- keylen  in  1  0 = AES-128 (Nr=10), 1 = AES-256 (Nr=14).
- round  out  4  index of the round key requested this cycle.
- round_key  in  128  round key for index round, supplied combinationally by key memory.
- block  in  128  ciphertext, sampled in the INIT cycle.
- new_block  out  128  working state; holds plaintext once ready rises.
- ready  out  1  high = idle with the result valid.
REQ-003 The block SHALL use one clock, with an asynchronous, active-high reset.

Function
REQ-004 Algorithm SHALL be the FIPS-197 inverse cipher:
- AddRoundKey(Nr);
- then rounds r=Nr-1..1: InvShiftRows, InvSubBytes, AddRoundKey(r), InvMixColumns;
- then final round: InvShiftRows, InvSubBytes, AddRoundKey(0).
REQ-005 The FSM SHALL have states IDLE, INIT, SHIFT, SBOX, MAIN.
REQ-006 IDLE:
- next=1 latches keylen, loads round counter with Nr, clears ready, and goes to INIT.
- next=0 holds all state.
REQ-007 INIT:
- new_block <= block ^ round_key (round=Nr);
- round counter decrements;
- go to SHIFT.
REQ-008 SHIFT: new_block <= InvShiftRows(new_block) in one cycle; word counter reset to 0; go to SBOX.
REQ-009 SBOX: one 32-bit word per cycle, words w0..w3 in counter order, through the inverse S-box; go to MAIN after word 3 (4 cycles).
REQ-010 MAIN with round counter r>0:
- new_block <= InvMixColumns(new_block ^ round_key);
- round counter decrements;
- go to SHIFT.
REQ-011 MAIN with r=0:
- new_block <= new_block ^ round_key;
- ready <= 1;
- go to IDLE.
REQ-012 Latency: ready SHALL rise 61 (AES-128) / 85 (AES-256) rising edges after the edge that sampled next.
REQ-013 next SHALL be ignored in every state other than IDLE; keylen changes mid-operation SHALL have no effect.
REQ-014 The round output SHALL equal the round counter register at all times; round keys SHALL be consumed in order Nr, Nr-1, ..., 0, each exactly once.
REQ-015 new_block SHALL change only in INIT, SHIFT, SBOX and MAIN, and SHALL hold its value in IDLE.
REQ-016 next asserted in the same cycle that ready rises SHALL be ignored; next is sampled only in the following IDLE cycle.
REQ-017 Field arithmetic SHALL be GF(2^8) modulo 0x11b; InvMixColumns SHALL use coefficients 0e, 0b, 0d, 09; byte 0 is bits 127:120.

Reset
REQ-018 Reset SHALL take effect immediately, including mid-operation, and force:
- FSM to IDLE;
- ready=1;
- new_block=0;
- round=0;
- word counter=0;
- latched keylen=0.
REQ-019 After reset deasserts, the first next SHALL start a clean decryption with no residue from an aborted operation.

Structure
REQ-020 A shared package SHALL hold:
- keylen constants and round counts (10, 14);
- FSM state encodings;
- GF multiply helpers (gm2, gm4/gm8-based gm09/gm0b/gm0d/gm0e).
REQ-021 One sub-module, aes_inv_sbox, SHALL provide a combinational 32-bit inverse S-box (four byte lookups), instantiated once inside the block.

Verification
REQ-022 Bench SHALL supply round_key from a behavioural key-expansion model indexed by round, and SHALL cover:
- FIPS-197 App. B, AES-128: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> new_block 3243f6a8885a308d313198a2e0370734, ready after 61 edges.
- FIPS-197 C.1, AES-128: key 000102..0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> 00112233445566778899aabbccddeeff.
- FIPS-197 C.3, AES-256: key 000102..1f, ct 8ea2b7ca516745bfeafc49904b496089 -> 00112233445566778899aabbccddeeff, ready after 85 edges.
- next pulsed and keylen toggled mid-operation -> result and latency unchanged; round sequence 10,9,...,0 observed.
- reset asserted at cycle 30 of a decryption -> ready=1, new_block=0, round=0 immediately; a subsequent C.1 run passes.
- Back-to-back: next asserted on the cycle after ready rises -> second block correct; new_block holds between runs.
